// File: rtl/redun_mont_sq_sequencer_if.sv
// Operand/result handshake and multiplier bus between the VDF top level,
// the squaring sequencer and the shared multi-mode multiplier.
interface redun_mont_sq_sequencer_if #(
  parameter int unsigned NUM_ELEMENTS = 33,
  parameter int unsigned DSP_BIT_LEN  = 17,
  parameter int unsigned ITER_W       = 32
);
  localparam int unsigned OP_W = NUM_ELEMENTS * DSP_BIT_LEN;

  // Request side
  logic              i_valid;
  logic              o_ready;
  logic [OP_W-1:0]   i_sq_in;
  logic [ITER_W-1:0] i_iter;
  logic [OP_W-1:0]   i_mod;
  logic [OP_W-1:0]   i_mod_inv;

  // Result side
  logic              o_valid;
  logic              i_ready;
  logic [OP_W-1:0]   o_dat;
  logic [ITER_W-1:0] o_iter_cnt;

  // Multiplier side
  logic [2:0]        o_mul_ctl;
  logic [OP_W-1:0]   o_mul_a;
  logic [OP_W-1:0]   o_mul_b;
  logic [OP_W-1:0]   o_mul_add;
  logic [2*OP_W-1:0] i_mul_dat;

  // Sequencer view
  modport slave (
    input  i_valid, i_sq_in, i_iter, i_mod, i_mod_inv, i_ready, i_mul_dat,
    output o_ready, o_valid, o_dat, o_iter_cnt, o_mul_ctl, o_mul_a, o_mul_b, o_mul_add
  );

  // Environment view (top level plus multiplier)
  modport master (
    output i_valid, i_sq_in, i_iter, i_mod, i_mod_inv, i_ready, i_mul_dat,
    input  o_ready, o_valid, o_dat, o_iter_cnt, o_mul_ctl, o_mul_a, o_mul_b, o_mul_add
  );
endinterface

// File: rtl/redun_mont_sq_sequencer.sv
// Repeated Montgomery squaring sequencer: drives one shared multiplier
// through SQUARE / LOW / HIGH passes per iteration, x <- x^2 * R^-1 mod M.
module redun_mont_sq_sequencer #(
  parameter int unsigned NUM_ELEMENTS = 33,
  parameter int unsigned DSP_BIT_LEN  = 17,
  parameter int unsigned WORD_LEN     = 16,
  parameter int unsigned MUL_LAT      = 1,
  parameter int unsigned ITER_W       = 32
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  redun_mont_sq_sequencer_if.slave bus
);

  localparam int unsigned OP_W      = NUM_ELEMENTS * DSP_BIT_LEN;
  localparam int unsigned STEP_W    = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_LAT);

  localparam logic [2:0] CTL_SQ = 3'b001;
  localparam logic [2:0] CTL_LO = 3'b010;
  localparam logic [2:0] CTL_HI = 3'b100;

  // Words must carry at least one redundant bit and the multiplier needs a pipeline stage.
  if (WORD_LEN >= DSP_BIT_LEN || MUL_LAT < 1) begin : g_bad_param
    $error("redun_mont_sq_sequencer: invalid WORD_LEN/DSP_BIT_LEN/MUL_LAT");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q,  step_d;
  logic [OP_W-1:0]   x_q,     x_d;
  logic [OP_W-1:0]   t_lo_q,  t_lo_d;
  logic [OP_W-1:0]   t_hi_q,  t_hi_d;
  logic [OP_W-1:0]   q_q,     q_d;
  logic [OP_W-1:0]   m_q,     m_d;
  logic [OP_W-1:0]   minv_q,  minv_d;
  logic [ITER_W-1:0] iter_q,  iter_d;
  logic [ITER_W-1:0] cnt_q,   cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [OP_W-1:0]   dat_q,   dat_d;
  logic [2:0]        ctl_q,   ctl_d;
  logic [OP_W-1:0]   a_q,     a_d;
  logic [OP_W-1:0]   b_q,     b_d;
  logic [OP_W-1:0]   add_q,   add_d;

  logic [OP_W-1:0]   mul_lo_c;
  logic [OP_W-1:0]   mul_hi_c;
  logic              step_last_c;
  logic [ITER_W:0]   cnt_inc_c;
  logic              last_iter_c;

  // Product halves, end-of-step flag and overflow-free iteration compare
  assign mul_lo_c    = bus.i_mul_dat[OP_W-1:0];
  assign mul_hi_c    = bus.i_mul_dat[2*OP_W-1:OP_W];
  assign step_last_c = (step_q == STEP_LAST);
  assign cnt_inc_c   = {1'b0, cnt_q} + (ITER_W+1)'(1);
  assign last_iter_c = (cnt_inc_c == {1'b0, iter_q});

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_dat      = dat_q;
  assign bus.o_iter_cnt = cnt_q;
  assign bus.o_mul_ctl  = ctl_q;
  assign bus.o_mul_a    = a_q;
  assign bus.o_mul_b    = b_q;
  assign bus.o_mul_add  = add_q;

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      t_lo_q  <= '0;
      t_hi_q  <= '0;
      q_q     <= '0;
      m_q     <= '0;
      minv_q  <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dat_q   <= '0;
      ctl_q   <= CTL_LO;
      a_q     <= '0;
      b_q     <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      t_lo_q  <= t_lo_d;
      t_hi_q  <= t_hi_d;
      q_q     <= q_d;
      m_q     <= m_d;
      minv_q  <= minv_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      dat_q   <= dat_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      add_q   <= add_d;
    end
  end

  // Next state, capture and next-step operand selection
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    t_lo_d  = t_lo_q;
    t_hi_d  = t_hi_q;
    q_d     = q_q;
    m_d     = m_q;
    minv_d  = minv_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dat_d   = dat_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    add_d   = add_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid && ready_q) begin
          x_d    = bus.i_sq_in;
          m_d    = bus.i_mod;
          minv_d = bus.i_mod_inv;
          iter_d = bus.i_iter;
          cnt_d  = '0;
          step_d = '0;
          if (bus.i_iter == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SQ;
            ctl_d   = CTL_SQ;
            a_d     = bus.i_sq_in;
            b_d     = bus.i_sq_in;
            add_d   = '0;
          end
        end
      end

      S_SQ: begin
        if (step_last_c) begin
          t_lo_d  = mul_lo_c;
          t_hi_d  = mul_hi_c;
          step_d  = '0;
          state_d = S_LO;
          ctl_d   = CTL_LO;
          a_d     = mul_lo_c;
          b_d     = minv_q;
          add_d   = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      S_LO: begin
        if (step_last_c) begin
          q_d     = mul_lo_c;
          step_d  = '0;
          state_d = S_HI;
          ctl_d   = CTL_HI;
          a_d     = mul_lo_c;
          b_d     = m_q;
          add_d   = t_hi_q;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      S_HI: begin
        if (step_last_c) begin
          x_d    = mul_lo_c;
          cnt_d  = cnt_inc_c[ITER_W-1:0];
          step_d = '0;
          if (last_iter_c) begin
            state_d = S_DONE;
            ctl_d   = CTL_LO;
          end else begin
            state_d = S_SQ;
            ctl_d   = CTL_SQ;
            a_d     = mul_lo_c;
            b_d     = mul_lo_c;
            add_d   = '0;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      S_DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          dat_d   = x_q;
        end else if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ctl_d   = CTL_LO;
        valid_d = 1'b0;
      end
    endcase
  end

  // Ready is a registered view of the upcoming IDLE state
  always_comb begin
    ready_d = 1'b0;
    if (state_d == S_IDLE) begin
      ready_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_redun_mont_sq_sequencer.sv
// Scoreboard bench for the Montgomery squaring sequencer with a behavioural
// multiplier (N=4, 17-bit words, 16-bit radix); MUL_LAT=1 and MUL_LAT=3 instances.
module tb_redun_mont_sq_sequencer;
  localparam int unsigned N   = 4;
  localparam int unsigned DSP = 17;
  localparam int unsigned WL  = 16;
  localparam int unsigned IW  = 32;
  localparam int unsigned DW  = N * DSP;
  localparam int unsigned PW  = 2 * DW;
  localparam logic [255:0] MASK64 = {192'd0, {64{1'b1}}};
  localparam logic [63:0]  MOD    = 64'hFFFF_FFFF_FFFF_FFC5;
  localparam logic [63:0]  X3     = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0]  X4     = 64'h0FED_CBA9_8765_4321;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mi;

  redun_mont_sq_sequencer_if #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(DSP), .ITER_W(IW)) bus0 ();
  redun_mont_sq_sequencer_if #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(DSP), .ITER_W(IW)) bus1 ();

  redun_mont_sq_sequencer #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(DSP), .WORD_LEN(WL), .MUL_LAT(1), .ITER_W(IW))
    u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  redun_mont_sq_sequencer #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(DSP), .WORD_LEN(WL), .MUL_LAT(3), .ITER_W(IW))
    u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  // ---------------- arithmetic helpers ----------------
  function automatic logic [255:0] w2i(input logic [PW-1:0] w, input int nw);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < nw; i++) v = v + (256'(w[i*DSP +: DSP]) << (WL * i));
    return v;
  endfunction

  function automatic logic [PW-1:0] i2w(input logic [255:0] v, input int nw);
    logic [PW-1:0] w;
    w = '0;
    for (int i = 0; i < nw; i++) w[i*DSP +: DSP] = DSP'(v[i*WL +: WL]);
    return w;
  endfunction

  function automatic logic [DW-1:0] wd(input logic [63:0] x);
    return DW'(i2w(256'(x), N));
  endfunction

  function automatic logic [63:0] minv_of(input logic [63:0] m);
    logic [63:0] inv;
    inv = m;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - m * inv);
    return -inv;
  endfunction

  // Golden: t Montgomery squarings, fully reduced
  function automatic logic [63:0] golden(input logic [63:0] x0, input int t);
    logic [255:0] x, tt, q, mm, mv;
    x  = 256'(x0);
    mm = 256'(MOD);
    mv = 256'(minv_of(MOD));
    for (int i = 0; i < t; i++) begin
      tt = x * x;
      q  = ((tt & MASK64) * mv) & MASK64;
      x  = (tt + q * mm) >> 64;
      if (x >= mm) x = x - mm;
    end
    return x[63:0];
  endfunction

  // Behavioural multiplier: HIGH mode folds in the T_lo seen during LOW and reduces mod B
  function automatic logic [PW-1:0] mul_fn(input logic [2:0] ctl, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] add,
                                           input logic [255:0] tlo);
    logic [255:0] ia, ib, p;
    ia = w2i(PW'(a), N);
    ib = w2i(PW'(b), N);
    p  = ia * ib;
    case (ctl)
      3'b001:  return i2w(p, 2 * N);
      3'b010:  return i2w(p, N);
      3'b100: begin
        p = ((tlo + p) >> (WL * N)) + w2i(PW'(add), N);
        if (ib != '0) p = p % ib;
        return i2w(p, N);
      end
      default: return '0;
    endcase
  endfunction

  logic [255:0]  tlo0, tlo1;
  logic [PW-1:0] p0;
  logic [PW-1:0] p3 [3];

  always @(posedge clk) begin
    if (bus0.o_mul_ctl == 3'b010) tlo0 <= w2i(PW'(bus0.o_mul_a), N);
    if (bus1.o_mul_ctl == 3'b010) tlo1 <= w2i(PW'(bus1.o_mul_a), N);
    p0    <= mul_fn(bus0.o_mul_ctl, bus0.o_mul_a, bus0.o_mul_b, bus0.o_mul_add, tlo0);
    p3[0] <= mul_fn(bus1.o_mul_ctl, bus1.o_mul_a, bus1.o_mul_b, bus1.o_mul_add, tlo1);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus0.i_mul_dat = p0;
  assign bus1.i_mul_dat = p3[2];

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] dat;
    logic [IW-1:0] cnt;
    int            acc;
    int            lat;
  } exp_t;
  exp_t sb[$];

  logic          pv [2];
  logic [2:0]    pc [2];
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [2];
  logic [DW-1:0] pd [2];
  int            rl [2];
  logic          prst;
  logic          hs0, hs1;

  always @(posedge clk) begin
    hs0 <= bus0.o_valid & bus0.i_ready;
    hs1 <= bus1.o_valid & bus1.i_ready;
  end

  task automatic mon(input int id, input logic vld, input logic [DW-1:0] dat, input logic [IW-1:0] cnt,
                     input logic [2:0] ctl, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] add, input logic hs, input int lat_l);
    exp_t e;
    chk($sformatf("onehot%0d", id), 256'($onehot(ctl)), 256'd1);
    if (rst_n && prst) begin
      if (ctl == pc[id]) begin
        rl[id]++;
        chk($sformatf("op_stable%0d", id), 256'({a, b, add}), 256'({pa[id], pb[id], pd[id]}));
      end else begin
        if (pc[id] == 3'b001 || pc[id] == 3'b100)
          chk($sformatf("step_len%0d", id), 256'(rl[id]), 256'(lat_l + 1));
        rl[id] = 1;
      end
      if (hs) chk($sformatf("valid_drop%0d", id), 256'(vld), 256'd0);
      if (vld && !pv[id]) begin
        if (sb.size() == 0) begin
          chk($sformatf("spurious_valid%0d", id), 256'(vld), 256'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 256'(id), 256'(e.id));
          chk($sformatf("dat%0d", id), 256'(dat), 256'(e.dat));
          chk($sformatf("iter_cnt%0d", id), 256'(cnt), 256'(e.cnt));
          chk($sformatf("latency%0d", id), 256'(cyc - e.acc), 256'(e.lat));
        end
      end
    end else begin
      rl[id] = 1;
    end
    pv[id] = vld;
    pc[id] = ctl;
    pa[id] = a;
    pb[id] = b;
    pd[id] = add;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.o_valid, bus0.o_dat, bus0.o_iter_cnt, bus0.o_mul_ctl, bus0.o_mul_a, bus0.o_mul_b,
        bus0.o_mul_add, hs0, 1);
    mon(1, bus1.o_valid, bus1.o_dat, bus1.o_iter_cnt, bus1.o_mul_ctl, bus1.o_mul_a, bus1.o_mul_b,
        bus1.o_mul_add, hs1, 3);
    prst = rst_n;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int id, input logic v, input logic [DW-1:0] x, input logic [IW-1:0] t);
    if (id == 0) begin
      bus0.i_valid = v; bus0.i_sq_in = x; bus0.i_iter = t;
      bus0.i_mod = wd(MOD); bus0.i_mod_inv = wd(mi);
    end else begin
      bus1.i_valid = v; bus1.i_sq_in = x; bus1.i_iter = t;
      bus1.i_mod = wd(MOD); bus1.i_mod_inv = wd(mi);
    end
  endtask

  task automatic issue(input int id, input logic [63:0] x, input logic [IW-1:0] t,
                       input logic [63:0] exp_v, input int exp_lat, input bit push);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (((id == 0) ? bus0.o_ready : bus1.o_ready) !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 256'(w < 200), 256'd1);
    drive(id, 1'b1, wd(x), t);
    @(posedge clk);
    #1;
    e.id  = id;
    e.dat = wd(exp_v);
    e.cnt = t;
    e.acc = cyc;
    e.lat = exp_lat;
    if (push) sb.push_back(e);
    drive(id, 1'b0, wd(x), t);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || bus0.o_valid || bus1.o_valid || !bus0.o_ready || !bus1.o_ready) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", 256'(w < 500), 256'd1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ready"}, 256'(bus0.o_ready),    256'd1);
    chk({tag, "_valid"}, 256'(bus0.o_valid),    256'd0);
    chk({tag, "_dat"},   256'(bus0.o_dat),      256'd0);
    chk({tag, "_cnt"},   256'(bus0.o_iter_cnt), 256'd0);
    chk({tag, "_ctl"},   256'(bus0.o_mul_ctl),  256'd2);
    chk({tag, "_ops"},   256'({bus0.o_mul_a, bus0.o_mul_b, bus0.o_mul_add}), 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [63:0] g41;
    pv = '{1'b0, 1'b0};
    pc = '{3'b010, 3'b010};
    pa = '{'0, '0};
    pb = '{'0, '0};
    pd = '{'0, '0};
    rl = '{1, 1};
    prst = 1'b0;
    mi = minv_of(MOD);
    bus0.i_ready = 1'b1;
    bus1.i_ready = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst_chk("por");
    rst_n = 1'b1;

    // T=0 passthrough
    issue(0, 64'h1234, 0, 64'h1234, 1, 1'b1);
    wait_idle();

    // T=1 with x = R mod M = 59 is a fixed point
    issue(0, 64'd59, 1, 64'd59, 7, 1'b1);
    wait_idle();

    // T=5 then a back-to-back T=2 request
    issue(0, X3, 5, golden(X3, 5), 31, 1'b1);
    issue(0, X4, 2, golden(X4, 2), 13, 1'b1);
    wait_idle();

    // Result held while downstream stalls; new requests ignored
    g41 = golden(64'd1, 1);
    bus0.i_ready = 1'b0;
    issue(0, 64'd1, 1, g41, 7, 1'b1);
    w = 0;
    while (bus0.o_valid !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("hold_wait", 256'(w < 100), 256'd1);
    repeat (10) begin
      @(negedge clk);
      drive(0, 1'b1, wd(64'h55), 3);
      chk("hold_valid", 256'(bus0.o_valid), 256'd1);
      chk("hold_dat",   256'(bus0.o_dat),   256'(wd(g41)));
      chk("hold_ready", 256'(bus0.o_ready), 256'd0);
    end
    drive(0, 1'b0, wd(64'h55), 3);
    bus0.i_ready = 1'b1;
    wait_idle();

    // Async reset in the LOW pass of iteration 2
    issue(0, X3, 3, 64'd0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_ctl", 256'(bus0.o_mul_ctl),  256'd2);
    chk("mid_cnt", 256'(bus0.o_iter_cnt), 256'd1);
    rst_n = 1'b0;
    #1;
    rst_chk("async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(0, 64'd59, 1, 64'd59, 7, 1'b1);
    wait_idle();

    // MUL_LAT=3 instance, T=2
    issue(1, X4, 2, golden(X4, 2), 25, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
